button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_pkg.sv | 19 +
 rtl/button_event_decoder.sv | 141 ++++++++++++++
 tb/tb_button_event_decoder.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared types for the button gesture decoder.
// Event codes and FSM state encoding.
package button_event_pkg;

  typedef enum logic [1:0] {
    EVT_SHORT  = 2'd0,
    EVT_DOUBLE = 2'd1,
    EVT_LONG   = 2'd2
  } evt_code_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT_GAP  = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/button_event_decoder.sv
// Classifies a debounced button into SHORT / DOUBLE / LONG events.
// Ports: clk, rst (sync, active-high), i_sig_debounced, i_evt_ready,
//   i_ovf_clr -> o_evt_valid, o_evt_code, o_evt_ovf (sticky), o_busy.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int unsigned N_LONG = 19,
  parameter int unsigned N_GAP  = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sig_debounced,
  input  logic       i_evt_ready,
  input  logic       i_ovf_clr,
  output logic       o_evt_valid,
  output logic [1:0] o_evt_code,
  output logic       o_evt_ovf,
  output logic       o_busy
);

  localparam int unsigned CW =
    (N_LONG > N_GAP) ? N_LONG : N_GAP;
  localparam logic [CW-1:0] ALL1 = '1;
  localparam logic [CW-1:0] LONG_END =
    ALL1 >> (CW - N_LONG);
  localparam logic [CW-1:0] GAP_END =
    ALL1 >> (CW - N_GAP);

  logic          sig_q, sig_d;
  logic          rise, fall;
  fsm_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gen;
  evt_code_t     gen_code;
  logic          valid_q, valid_d;
  evt_code_t     code_q, code_d;
  logic          ovf_q, ovf_d;
  logic          drop;

  assign sig_d = i_sig_debounced;
  assign rise  = i_sig_debounced & ~sig_q;
  assign fall  = ~i_sig_debounced & sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q   <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= EVT_SHORT;
      ovf_q   <= 1'b0;
    end else begin
      sig_q   <= sig_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  // Terminal compares leave the counting state before
  // the counter could wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gen      = 1'b0;
    gen_code = EVT_SHORT;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESS1;
          cnt_d   = '0;
        end
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_END) begin
          gen      = 1'b1;
          gen_code = EVT_LONG;
          state_d  = ST_LONG_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_GAP: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == GAP_END) begin
          gen      = 1'b1;
          gen_code = EVT_SHORT;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          gen      = 1'b1;
          gen_code = EVT_DOUBLE;
          state_d  = ST_IDLE;
        end
      end
      ST_LONG_HELD: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new event may replace the pending one only on the
  // accepting cycle; otherwise it is dropped and flagged.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    drop    = 1'b0;
    if (valid_q && i_evt_ready) valid_d = 1'b0;
    if (gen) begin
      if (!valid_q || i_evt_ready) begin
        valid_d = 1'b1;
        code_d  = gen_code;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) ovf_d = 1'b1;
    else if (i_ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    o_busy = (state_q != ST_IDLE);
  end

  assign o_evt_valid = valid_q;
  assign o_evt_code  = code_q;
  assign o_evt_ovf   = ovf_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder.
// Directed gesture scenarios plus a randomized trace run.
module tb_button_event_decoder;

  localparam logic [1:0] C_SHORT  = 2'd0;
  localparam logic [1:0] C_DOUBLE = 2'd1;
  localparam logic [1:0] C_LONG   = 2'd2;
  localparam int LONG_CYC = 16;
  localparam int GAP_CYC  = 8;
  localparam int T = 1500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig = 1'b0;
  logic       rdy = 1'b1;
  logic       clr = 1'b0;
  logic       o_valid;
  logic [1:0] o_code;
  logic       o_ovf;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  bit       sa [T];
  bit       ra [T];
  bit       ca [T];
  bit       gv [T];
  bit [1:0] gc [T];
  bit       eb [T];
  bit       ev [T];
  bit [1:0] ec [T];
  bit       eo [T];

  button_event_decoder #(.N_LONG(4), .N_GAP(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_sig_debounced (sig),
    .i_evt_ready     (rdy),
    .i_ovf_clr       (clr),
    .o_evt_valid     (o_valid),
    .o_evt_code      (o_code),
    .o_evt_ovf       (o_ovf),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sig = 1'b0;
    rdy = 1'b1;
    clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sig = 1'b1;
    rdy = 1'b0;
    repeat (25) step();
    do_reset();
    total++;
    if ({o_valid, o_code, o_ovf, o_busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_state got v=%b c=%0d o=%b b=%b want all 0",
               o_valid, o_code, o_ovf, o_busy);
    end
  endtask

  task automatic test_short();
    int nv = 0, first = 0;
    logic [1:0] code = 2'd3;
    logic b8 = 1'b0, b9 = 1'b1;
    do_reset();
    sig = 1'b1;
    repeat (5) step();
    sig = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_valid) begin
        nv++;
        if (first == 0) first = k;
        code = o_code;
      end
      if (k == 8) b8 = o_busy;
      if (k == 9) b9 = o_busy;
    end
    total++;
    if (nv !== 1 || first !== 9) begin
      bad++;
      $display("FAIL short_timing got n=%0d at=%0d want n=1 at=9",
               nv, first);
    end
    total++;
    if (code !== C_SHORT) begin
      bad++;
      $display("FAIL short_code got %0d want %0d", code, C_SHORT);
    end
    total++;
    if (b8 !== 1'b1 || b9 !== 1'b0) begin
      bad++;
      $display("FAIL short_busy got %b%b want 10", b8, b9);
    end
  endtask

  task automatic test_double();
    int nv = 0, first = 0;
    logic [1:0] code = 2'd3;
    do_reset();
    sig = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) sig = 1'b0;
      if (k == 8) sig = 1'b1;
      step();
      if (o_valid) nv++;
    end
    sig = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_valid) begin
        nv++;
        if (first == 0) first = k;
        code = o_code;
      end
    end
    total++;
    if (nv !== 1 || first !== 1) begin
      bad++;
      $display("FAIL double_timing got n=%0d at=%0d want n=1 at=1",
               nv, first);
    end
    total++;
    if (code !== C_DOUBLE) begin
      bad++;
      $display("FAIL double_code got %0d want %0d", code, C_DOUBLE);
    end
  endtask

  task automatic test_long();
    int nv = 0, first = 0;
    logic [1:0] code = 2'd3;
    logic b30 = 1'b0;
    do_reset();
    sig = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 31) sig = 1'b0;
      step();
      if (o_valid) begin
        nv++;
        if (first == 0) first = k;
        code = o_code;
      end
      if (k == 30) b30 = o_busy;
    end
    total++;
    if (nv !== 1 || first !== LONG_CYC + 1) begin
      bad++;
      $display("FAIL long_timing got n=%0d at=%0d want n=1 at=%0d",
               nv, first, LONG_CYC + 1);
    end
    total++;
    if (code !== C_LONG) begin
      bad++;
      $display("FAIL long_code got %0d want %0d", code, C_LONG);
    end
    total++;
    if (b30 !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL long_busy got %b%b want 10", b30, o_busy);
    end
  endtask

  task automatic test_ovf();
    do_reset();
    rdy = 1'b0;
    sig = 1'b1;
    repeat (3) step();
    sig = 1'b0;
    repeat (12) step();
    sig = 1'b1;
    repeat (20) step();
    sig = 1'b0;
    repeat (3) step();
    total++;
    if (o_valid !== 1'b1 || o_code !== C_SHORT || o_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop got v=%b c=%0d o=%b want v=1 c=0 o=1",
               o_valid, o_code, o_ovf);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if (o_ovf !== 1'b0 || o_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clear got o=%b v=%b want o=0 v=1",
               o_ovf, o_valid);
    end
    rdy = 1'b1;
    step();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_accept got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    do_reset();
    rdy = 1'b0;
    sig = 1'b1;
    repeat (20) step();
    sig = 1'b0;
    repeat (2) step();
    sig = 1'b1;
    repeat (3) step();
    sig = 1'b0;
    repeat (2) step();
    total++;
    if (o_valid !== 1'b1 || o_code !== C_LONG || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup got v=%b c=%0d b=%b want 1 2 1",
               o_valid, o_code, o_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({o_valid, o_code, o_ovf, o_busy} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset got v=%b c=%0d o=%b b=%b want all 0",
               o_valid, o_code, o_ovf, o_busy);
    end
    rdy = 1'b1;
    repeat (20) begin
      step();
      if (o_valid) nv++;
    end
    total++;
    if (nv !== 0) begin
      bad++;
      $display("FAIL mid_no_event got n=%0d want 0", nv);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy = 1'b0;
    sig = 1'b1;
    repeat (3) step();
    sig = 1'b0;
    repeat (12) step();
    sig = 1'b1;
    repeat (LONG_CYC) step();
    rdy = 1'b1;
    step();
    total++;
    if (o_valid !== 1'b1 || o_code !== C_LONG || o_ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b_load got v=%b c=%0d o=%b want 1 2 0",
               o_valid, o_code, o_ovf);
    end
    step();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got v=%b want 0", o_valid);
    end
    sig = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_high();
    int first = 0;
    logic [1:0] code = 2'd3;
    rst = 1'b1;
    rdy = 1'b1;
    sig = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_valid && first == 0) begin
        first = k;
        code = o_code;
      end
    end
    total++;
    if (first !== LONG_CYC + 1 || code !== C_LONG) begin
      bad++;
      $display("FAIL reset_high got at=%0d c=%0d want at=%0d c=2",
               first, code, LONG_CYC + 1);
    end
    sig = 1'b0;
    repeat (3) step();
  endtask

  // Reference: gestures found from run lengths of the
  // input trace, then a one-slot output buffer.
  task automatic build_model();
    int t, r, f, r2, f2, e;
    bit v, o;
    bit [1:0] c;
    for (int i = 0; i < T; i++) begin
      gv[i] = 0;
      gc[i] = 0;
      eb[i] = 0;
    end
    t = 0;
    while (t < T) begin
      r = t;
      while (r < T && !sa[r]) r++;
      if (r >= T) break;
      f = r + 1;
      while (f < T && sa[f]) f++;
      if (f >= T) break;
      if (f > r + LONG_CYC) begin
        gv[r + LONG_CYC] = 1;
        gc[r + LONG_CYC] = C_LONG;
        e = f;
      end else begin
        r2 = f + 1;
        while (r2 < T && !sa[r2]) r2++;
        if (r2 > f + GAP_CYC) begin
          if (f + GAP_CYC >= T) break;
          gv[f + GAP_CYC] = 1;
          gc[f + GAP_CYC] = C_SHORT;
          e = f + GAP_CYC;
        end else begin
          f2 = r2 + 1;
          while (f2 < T && sa[f2]) f2++;
          if (f2 >= T) break;
          gv[f2] = 1;
          gc[f2] = C_DOUBLE;
          e = f2;
        end
      end
      for (int b = r + 1; b <= e && b < T; b++) eb[b] = 1;
      t = e + 1;
    end
    v = 0;
    c = 0;
    o = 0;
    for (int i = 0; i < T; i++) begin
      ev[i] = v;
      ec[i] = c;
      eo[i] = o;
      if (gv[i] && v && !ra[i]) o = 1;
      else if (ca[i]) o = 0;
      if (gv[i] && (!v || ra[i])) begin
        v = 1;
        c = gc[i];
      end else if (v && ra[i]) begin
        v = 0;
      end
    end
  endtask

  task automatic test_random();
    int i = 0, n;
    bit lvl = 0;
    for (int k = 0; k < T; k++) sa[k] = 0;
    i = 5;
    while (i < T - 40) begin
      if (lvl)
        n = ($urandom_range(0, 3) == 0) ?
            $urandom_range(14, 18) : $urandom_range(1, 30);
      else
        n = ($urandom_range(0, 2) == 0) ?
            $urandom_range(6, 10) : $urandom_range(1, 14);
      for (int k = 0; k < n && i < T - 40; k++) begin
        sa[i] = lvl;
        i++;
      end
      lvl = !lvl;
    end
    for (int k = 0; k < T; k++) begin
      ra[k] = ($urandom_range(0, 3) != 0);
      ca[k] = ($urandom_range(0, 15) == 0);
    end
    build_model();
    do_reset();
    for (int k = 0; k < T; k++) begin
      total++;
      if (o_valid !== ev[k] || o_code !== ec[k]) begin
        bad++;
        $display("FAIL rnd_evt cyc=%0d got v=%b c=%0d want v=%b c=%0d",
                 k, o_valid, o_code, ev[k], ec[k]);
      end
      total++;
      if (o_ovf !== eo[k]) begin
        bad++;
        $display("FAIL rnd_ovf cyc=%0d got %b want %b",
                 k, o_ovf, eo[k]);
      end
      total++;
      if (o_busy !== eb[k]) begin
        bad++;
        $display("FAIL rnd_busy cyc=%0d got %b want %b",
                 k, o_busy, eb[k]);
      end
      sig = sa[k];
      rdy = ra[k];
      clr = ca[k];
      step();
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_double();
    test_long();
    test_ovf();
    test_reset_mid();
    test_back_to_back();
    test_reset_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
